// File: rtl/rle_stream_encoder.sv
// Streaming run-length encoder: symbols in over valid/ready, {value,count} tokens
// out through a small token FIFO; in_last closes the open run and ends the packet.
module rle_stream_encoder #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [DATA_W+CNT_W-1:0] out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAXC    = '1;
  localparam logic [AW:0]      OCC_LIM = (AW+1)'(FIFO_DEPTH - 2);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [CNT_W-1:0]  cnt;
    logic              last;
  } tok_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state, w_nstate;
  logic [DATA_W-1:0] r_val, w_nval;
  logic [CNT_W-1:0]  r_cnt, w_ncnt;
  logic              w_push0, w_push1, w_accept, w_pop;
  tok_t              w_tok0, w_tok1;

  tok_t              r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp, w_wp1;
  logic [AW:0]       r_occ;

  // Two free slots are always needed since one beat may close a run and emit a
  // last token together; a pop in the same cycle is deliberately ignored.
  assign in_ready  = (r_occ <= OCC_LIM);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_occ != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = {r_mem[r_rp].val, r_mem[r_rp].cnt};
  assign out_last  = r_mem[r_rp].last;
  assign w_wp1     = r_wp + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_val   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_val   <= w_nval;
      r_cnt   <= w_ncnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nval   = r_val;
    w_ncnt   = r_cnt;
    w_push0  = 1'b0;
    w_push1  = 1'b0;
    w_tok0   = '0;
    w_tok1   = '0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (in_last) begin
            w_push0 = 1'b1;
            w_tok0  = '{val: in_data, cnt: CNT_W'(1), last: 1'b1};
          end else begin
            w_nstate = RUN;
            w_nval   = in_data;
            w_ncnt   = CNT_W'(1);
          end
        end
        RUN: begin
          if (in_data == r_val && r_cnt != MAXC) begin
            if (in_last) begin
              w_push0  = 1'b1;
              w_tok0   = '{val: r_val, cnt: r_cnt + CNT_W'(1), last: 1'b1};
              w_nstate = IDLE;
            end else begin
              w_ncnt = r_cnt + CNT_W'(1);
            end
          end else begin
            // Saturated run and value change are the same case: close the
            // current run and restart with the incoming symbol at count 1.
            w_push0 = 1'b1;
            w_tok0  = '{val: r_val, cnt: r_cnt, last: 1'b0};
            w_nval  = in_data;
            w_ncnt  = CNT_W'(1);
            if (in_last) begin
              w_push1  = 1'b1;
              w_tok1   = '{val: in_data, cnt: CNT_W'(1), last: 1'b1};
              w_nstate = IDLE;
            end
          end
        end
        default: w_nstate = IDLE;
      endcase
    end
  end

  // Token FIFO; the closing token goes to the lower slot so it drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (w_push0) r_mem[r_wp]  <= w_tok0;
      if (w_push1) r_mem[w_wp1] <= w_tok1;
      r_wp  <= r_wp + AW'(w_push0) + AW'(w_push1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_occ <= r_occ + (AW+1)'(w_push0) + (AW+1)'(w_push1) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_rle_stream_encoder.sv
// Randomized bench: input beats are logged, expected tokens derived by splitting
// each finished packet into runs of at most MAXC, and compared to observed tokens.
module tb_rle_stream_encoder;
  localparam int DW = 8, CW = 8, DEPTH = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [DW+CW-1:0] out_data;
  logic out_last, out_valid, out_ready = 1'b0;

  rle_stream_encoder #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] v; int c; logic l; } tok_s;

  int total = 0, bad = 0;
  int or_mode = 1;              // 0: out_ready low, 1: high, 2: random
  logic [DW:0] beats[$];        // {last, data} of every accepted beat
  tok_s got_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: stall stability, out_ready drive, token capture.
  logic pv_stall = 1'b0, p_last = 1'b0;
  logic [DW+CW-1:0] p_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_stall = 1'b0;
    end else begin
      if (pv_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(p_data));
        chk("stall_last", 64'(out_last), 64'(p_last));
      end
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready)
        got_q.push_back('{out_data[DW+CW-1:CW], int'(out_data[CW-1:0]), out_last});
      pv_stall = out_valid && !out_ready;
      p_data   = out_data;
      p_last   = out_last;
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 1000) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    beats.push_back({l, d});
  endtask

  task automatic verify(input string name);
    tok_s exp_q[$];
    logic [DW-1:0] pkt[$];
    int n = 0;
    in_valid = 1'b0;
    or_mode = 1;
    while (out_valid && n < 2000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk({name, "_drained"}, 64'(out_valid), 64'd0);
    foreach (beats[b]) begin
      pkt.push_back(beats[b][DW-1:0]);
      if (beats[b][DW]) begin
        int i = 0;
        while (i < pkt.size()) begin
          logic [DW-1:0] v = pkt[i];
          int len = 0;
          while (i < pkt.size() && pkt[i] == v) begin len++; i++; end
          while (len > 0) begin
            int c = (len > MAXC) ? MAXC : len;
            len -= c;
            exp_q.push_back('{v, c, (i == pkt.size() && len == 0)});
          end
        end
        pkt.delete();
      end
    end
    chk({name, "_ntok"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      chk($sformatf("%s_val%0d", name, k), 64'(got_q[k].v), 64'(exp_q[k].v));
      chk($sformatf("%s_cnt%0d", name, k), 64'(got_q[k].c), 64'(exp_q[k].c));
      chk($sformatf("%s_last%0d", name, k), 64'(got_q[k].l), 64'(exp_q[k].l));
    end
    beats.delete();
    got_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send(8'hA5, 0); send(8'hA5, 0); send(8'hA5, 0); send(8'h3C, 1);
    verify("basic");

    for (int i = 0; i < 300; i++) send(8'h7E, 1'(i == 299));
    verify("long300");

    for (int i = 0; i < 255; i++) send(8'h55, 1'(i == 254));
    for (int i = 0; i < 256; i++) send(8'h66, 1'(i == 255));
    for (int i = 0; i < 510; i++) send(8'h77, 1'(i == 509));
    verify("maxc_edges");

    send(8'h11, 1); send(8'h22, 1);
    verify("single");

    or_mode = 0;
    @(negedge clk);
    send(8'h01, 0); send(8'h02, 0); send(8'h01, 0); send(8'h02, 0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    or_mode = 1;
    send(8'h02, 1);
    verify("backpressure");

    or_mode = 2;
    v = 8'($urandom_range(0, 3));
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 15) == 0) v = 8'($urandom_range(0, 3));
      send(v, 1'(i == 999));
    end
    verify("random1000");

    or_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) v = 8'($urandom);
      send(v, 1'(($urandom_range(0, 7) == 0) || i == 399));
    end
    verify("multipkt");

    or_mode = 0;
    @(negedge clk);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    beats.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    or_mode = 1;
    @(negedge clk);
    send(8'h09, 1);
    verify("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
